// File: rtl/alu_pkg.sv
// Shared types for the TinyALU command sequencer: opcodes, FSM states and the
// queued command layout.
package alu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add    = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul    = 3'b100,
      rst_op = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DROP  = 2'd2
   } state_t;

   // Op is kept as raw bits so illegal encodings survive the FIFO.
   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   function automatic logic is_illegal(input logic [2:0] op);
      return (op == 3'b101) || (op == 3'b110);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO; a write while full is refused even if a pop happens
// on the same edge.
module alu_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PtrLast = AW'(DEPTH - 1);
   localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_ok, rd_ok;

   assign full_o    = (count_q == CntFull);
   assign empty_o   = (count_q == '0);
   assign wr_ok     = wr_en_i && !full_o;
   assign rd_ok     = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/tinyalu_cmd_sequencer.sv
// Queues upstream ALU commands, issues them one at a time to the TinyALU and
// returns results in order through a single-entry response slot.
module tinyalu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_A,
   input  logic [7:0]  cmd_B,
   input  logic [2:0]  cmd_op,
   output logic        alu_start,
   output logic [7:0]  alu_A,
   output logic [7:0]  alu_B,
   output logic [2:0]  alu_op,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        busy,
   output logic        err
);

   localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

   cmd_t          head;
   logic          pop, fifo_full, fifo_empty, slot_free;
   state_t        state_q, state_d;
   logic          alu_start_q, alu_start_d;
   logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [15:0]   rsp_result_q, rsp_result_d;
   logic [2:0]    rsp_op_q, rsp_op_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   alu_cmd_fifo #(
      .DEPTH(DEPTH),
      .WIDTH($bits(cmd_t))
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en_i  (cmd_valid),
      .wr_data_i({cmd_op, cmd_A, cmd_B}),
      .rd_en_i  (pop),
      .rd_data_o(head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   assign cmd_ready  = !fifo_full && !reset;
   assign alu_start  = alu_start_q;
   assign alu_A      = alu_a_q;
   assign alu_B      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_op     = rsp_op_q;
   assign err        = err_q;
   assign busy       = !fifo_empty || (state_q != IDLE);

   // Issuing only into a free slot means a completion never finds it occupied.
   assign slot_free = !rsp_valid_q || rsp_ready;

   always_comb begin
      state_d      = state_q;
      alu_start_d  = alu_start_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q && !rsp_ready;
      rsp_result_d = rsp_result_q;
      rsp_op_d     = rsp_op_q;
      err_d        = 1'b0;
      cnt_d        = cnt_q;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               if (is_illegal(head.op)) begin
                  pop     = 1'b1;
                  err_d   = 1'b1;
                  state_d = DROP;
               end else if (head.op == no_op) begin
                  pop     = 1'b1;
                  state_d = DROP;
               end else if (slot_free) begin
                  pop         = 1'b1;
                  alu_start_d = 1'b1;
                  alu_a_d     = head.a;
                  alu_b_d     = head.b;
                  alu_op_d    = head.op;
                  cnt_d       = '0;
                  state_d     = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (alu_op_q == rst_op) begin
               alu_start_d = 1'b0;
               state_d     = IDLE;
            end else if (alu_done) begin
               alu_start_d  = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_result_d = alu_result;
               rsp_op_d     = alu_op_q;
               cnt_d        = '0;
               state_d      = IDLE;
            end else if (cnt_q == CntLast) begin
               alu_start_d  = 1'b0;
               err_d        = 1'b1;
               rsp_valid_d  = 1'b1;
               rsp_result_d = 16'hFFFF;
               rsp_op_d     = alu_op_q;
               cnt_d        = '0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DROP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         alu_start_q  <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= no_op;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_op_q     <= no_op;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         alu_start_q  <= alu_start_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_op_q     <= rsp_op_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule
